// File: rtl/vga_line_fetch_pkg.sv
`default_nettype none
// ==== vga_line_fetch_pkg : VGA 640x480 timing, 320x240 source geometry, fetch FSM types -- rev 1.0 ====
package vga_line_fetch_pkg;

  localparam int H_ACT_START   = 144;
  localparam int H_ACT_END     = 783;
  localparam int V_ACT_START   = 33;
  localparam int V_ACT_END     = 512;
  localparam int H_TOTAL       = 800;
  localparam int V_TOTAL       = 525;

  localparam int SRC_W         = 320;
  localparam int SRC_H         = 240;
  localparam int ADDR_W        = 17;
  localparam int PIX_W         = 8;
  localparam int X_W           = 9;

  localparam int FETCH_V_FIRST = V_ACT_START - 2;
  localparam int FETCH_V_LAST  = V_ACT_START + 2 * SRC_H - 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PIX_BLANK = 2'd0,
    PIX_UNDER = 2'd1,
    PIX_DATA  = 2'd2
  } pix_sel_e;

endpackage
`default_nettype wire

// File: rtl/vga_line_ram.sv
`default_nettype none
// ==== vga_line_ram : two 320x8 line banks, one write port, one registered read port -- rev 1.0 ====
module vga_line_ram
  import vga_line_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [X_W-1:0]   wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [X_W-1:0]   rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [2][SRC_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// ==== vga_line_fetch : fetches one source line per two VGA rows into a double-buffered
// ==== line RAM and pixel-doubles it onto the 640x480 active area -- rev 1.0 ====
module vga_line_fetch
  import vga_line_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE     = 17'd0,
  parameter int                MAX_OUTST   = 4,
  parameter logic [PIX_W-1:0]  UNDER_COLOR = 8'd9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [9:0]        h_pos,
  input  logic [9:0]        v_pos,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  color,
  output logic              underrun,
  output logic              busy
);

  fetch_state_e      state, state_nxt;
  logic [3:0]        out_cnt;
  logic [X_W-1:0]    issue_cnt;
  logic              fill_bank;
  logic [X_W-1:0]    wr_ptr [2];
  pix_sel_e          sel_q;
  logic [PIX_W-1:0]  ram_q;

  logic              fetch_trig, start_ok, accept, ret, wr_en;
  logic [7:0]        line_n;
  logic [ADDR_W-1:0] line_base;
  logic              active, ready;
  logic [X_W-1:0]    px;
  logic [7:0]        py;

  assign fetch_trig = (h_pos == 10'd0) && v_pos[0] &&
                      (v_pos >= 10'(FETCH_V_FIRST)) && (v_pos <= 10'(FETCH_V_LAST));
  assign line_n     = 8'((v_pos - 10'(FETCH_V_FIRST)) >> 1);
  assign line_base  = FB_BASE + ADDR_W'(line_n) * ADDR_W'(SRC_W);
  assign start_ok   = fetch_trig && (state == ST_IDLE);
  assign accept     = mem_req && mem_gnt;
  assign ret        = mem_rvalid && (state != ST_IDLE);
  assign wr_en      = ret && (wr_ptr[fill_bank] < X_W'(SRC_W));

  assign active = (h_pos >= 10'(H_ACT_START)) && (h_pos <= 10'(H_ACT_END)) &&
                  (v_pos >= 10'(V_ACT_START)) && (v_pos <= 10'(V_ACT_END));
  assign px     = X_W'((h_pos - 10'(H_ACT_START)) >> 1);
  assign py     = 8'((v_pos - 10'(V_ACT_START)) >> 1);
  // A pixel is shown only once its byte has landed for the bank's current fetch.
  assign ready  = wr_ptr[py[0]] > px;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A returning read frees its slot in the same cycle, so one new request may
  // go out alongside it without exceeding MAX_OUTST in flight.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_trig) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy    = 1'b1;
        mem_req = (out_cnt < 4'(MAX_OUTST)) || ret;
        if (mem_req && mem_gnt && (issue_cnt == X_W'(SRC_W - 1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((out_cnt == {3'd0, ret}) &&
            ((wr_ptr[fill_bank] + X_W'(wr_en)) == X_W'(SRC_W))) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_cnt   <= '0;
      issue_cnt <= '0;
      mem_addr  <= '0;
      fill_bank <= 1'b0;
      wr_ptr[0] <= '0;
      wr_ptr[1] <= '0;
      underrun  <= 1'b0;
      sel_q     <= PIX_BLANK;
    end else begin
      out_cnt <= out_cnt + {3'd0, accept} - {3'd0, ret};
      if (start_ok) begin
        fill_bank          <= line_n[0];
        issue_cnt          <= '0;
        mem_addr           <= line_base;
        wr_ptr[line_n[0]]  <= '0;
      end else begin
        if (accept) begin
          issue_cnt <= issue_cnt + 9'd1;
          mem_addr  <= mem_addr + 17'd1;
        end
        if (wr_en) wr_ptr[fill_bank] <= wr_ptr[fill_bank] + 9'd1;
      end
      if ((fetch_trig && (state != ST_IDLE)) || (active && !ready)) underrun <= 1'b1;
      if (!active)    sel_q <= PIX_BLANK;
      else if (ready) sel_q <= PIX_DATA;
      else            sel_q <= PIX_UNDER;
    end
  end

  vga_line_ram u_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_bank (fill_bank),
    .wr_addr (wr_ptr[fill_bank]),
    .wr_data (mem_rdata),
    .rd_en   (active),
    .rd_bank (py[0]),
    .rd_addr (px),
    .rd_data (ram_q)
  );

  always_comb begin
    color = '0;
    case (sel_q)
      PIX_DATA:  color = ram_q;
      PIX_UNDER: color = UNDER_COLOR;
      default:   color = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ==== tb_vga_line_fetch : directed bench with a color scoreboard and an in-order memory model -- rev 1.0 ====
module tb_vga_line_fetch;
  import vga_line_fetch_pkg::*;

  localparam logic [16:0] FB    = 17'd4096;
  localparam logic [7:0]  UNDER = 8'd9;

  logic        clk, rst;
  logic [9:0]  h_pos, v_pos;
  logic        mem_req, mem_gnt, mem_rvalid, underrun, busy;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata, color;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en;

  vga_line_fetch #(.FB_BASE(FB), .MAX_OUTST(4), .UNDER_COLOR(UNDER)) dut (
    .CLK(clk), .RST(rst), .h_pos(h_pos), .v_pos(v_pos),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .color(color), .underrun(underrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer content: byte at (x,y) is (x+y) mod 256.
  function automatic logic [7:0] pix_of(input logic [16:0] a);
    int off;
    off = int'(a) - int'(FB);
    if (off < 0 || off >= SRC_W * SRC_H) return 8'hEE;
    return 8'(((off % SRC_W) + (off / SRC_W)) % 256);
  endfunction

  function automatic logic [7:0] exp_color(input int h, input int v);
    if (h < H_ACT_START || h > H_ACT_END || v < V_ACT_START || v > V_ACT_END) return 8'd0;
    return 8'((((h - H_ACT_START) / 2) + ((v - V_ACT_START) / 2)) % 256);
  endfunction

  // In-order read memory: accept sampled late in the cycle, data returned
  // mem_lat clock edges after the accepting edge.
  typedef struct { logic [16:0] addr; int unsigned due; } rd_t;
  rd_t         mq[$];
  int unsigned nidx = 0;
  int unsigned mem_lat;
  int          max_out;

  always @(negedge clk) begin
    nidx++;
    if (rst) begin
      mq.delete();
      mem_rvalid = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (mq.size() > 0 && mq[0].due == nidx) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pix_of(mq[0].addr);
        void'(mq.pop_front());
      end
      #3;
      if (mem_req && mem_gnt) mq.push_back('{addr: mem_addr, due: nidx + mem_lat});
      if (mq.size() > max_out) max_out = mq.size();
    end
  end

  typedef struct { logic [7:0] want; bit chk; int h; int v; } sb_t;
  sb_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  // Present one pixel position; its color is compared one edge later.
  task automatic step(input int h, input int v, input bit chk, input logic [7:0] want);
    sb_t ent;
    h_pos = 10'(h);
    v_pos = 10'(v);
    sb.push_back('{want: want, chk: chk, h: h, v: v});
    @(posedge clk);
    #1;
    ent = sb.pop_front();
    if (ent.chk)
      check($sformatf("color h=%0d v=%0d", ent.h, ent.v), 32'(color), 32'(ent.want));
  endtask

  task automatic run_rows(input int v0, input int v1);
    bit trig;
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        trig = (h == 0) && (v % 2 == 1) && (v >= FETCH_V_FIRST) && (v <= FETCH_V_LAST);
        if (trig) check($sformatf("idle before trigger v=%0d", v), 32'(busy), 32'd0);
        step(h, v, chk_en, exp_color(h, v));
        if (trig) check($sformatf("busy after trigger v=%0d", v), 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    h_pos = '0;
    v_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_pos = '0; v_pos = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_lat = 1; max_out = 0; chk_en = 1'b1;

    do_reset();
    check("reset mem_req",  32'(mem_req),  32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset color",    32'(color),    32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    check("reset busy",     32'(busy),     32'd0);

    // Zero-latency memory, accept and return overlap every cycle.
    run_rows(31, 36);
    check("zero-lat max outstanding", 32'(max_out), 32'd1);
    check("zero-lat underrun", 32'(underrun), 32'd0);
    // Last two source lines; rows 507/508 show banks skipped by the jump.
    chk_en = 1'b0;
    run_rows(507, 508);
    chk_en = 1'b1;
    run_rows(509, 513);
    step(100, 35, 1'b1, 8'd0);
    step(300, 520, 1'b1, 8'd0);
    step(143, 100, 1'b1, 8'd0);
    step(783, 512, 1'b1, exp_color(783, 512));
    step(784, 512, 1'b1, 8'd0);
    check("last lines underrun", 32'(underrun), 32'd0);

    // Long-latency memory: data back in the 20th cycle counting the accept cycle.
    do_reset();
    mem_lat = 19; max_out = 0;
    run_rows(31, 38);
    check("long-lat max outstanding", 32'(max_out), 32'd4);
    check("long-lat underrun", 32'(underrun), 32'd0);

    // Grant withheld until v=33, h=200.
    mem_gnt = 1'b0; mem_lat = 1;
    do_reset();
    for (int v = 31; v <= 32; v++)
      for (int h = 0; h < H_TOTAL; h++) begin
        step(h, v, 1'b1, 8'd0);
        if (v == 32 && h == 400) begin
          check("stalled mem_req",  32'(mem_req),  32'd1);
          check("stalled mem_addr", 32'(mem_addr), 32'(FB));
        end
      end
    for (int h = 0; h < H_TOTAL; h++) begin
      if (h == 200) mem_gnt = 1'b1;
      step(h, 33, h <= 201, (h < H_ACT_START) ? 8'd0 : UNDER);
      if (h == 0) check("trigger while busy underrun", 32'(underrun), 32'd1);
    end
    check("stall underrun", 32'(underrun), 32'd1);
    for (int h = 0; h < H_TOTAL; h++) step(h, 34, 1'b0, 8'd0);
    check("stall underrun sticky", 32'(underrun), 32'd1);

    // Reset pulsed mid-fetch.
    mem_gnt = 1'b1;
    do_reset();
    for (int h = 0; h < 100; h++) step(h, 31, 1'b1, 8'd0);
    check("mid-fetch busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(100, 31, 1'b1, 8'd0);
    rst = 1'b0;
    check("post-reset mem_req", 32'(mem_req), 32'd0);
    check("post-reset busy",    32'(busy),    32'd0);
    for (int h = 101; h < H_TOTAL; h++) step(h, 31, 1'b1, 8'd0);
    for (int h = 0; h < H_TOTAL; h++) step(h, 32, 1'b1, 8'd0);
    check("post-reset idle before trigger", 32'(busy), 32'd0);
    step(0, 33, 1'b1, 8'd0);
    check("restart busy", 32'(busy), 32'd1);
    check("restart mem_addr", 32'(mem_addr), 32'(FB) + 32'(SRC_W));
    check("restart mem_req", 32'(mem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter FB_BASE, default 17'd0, meaning framebuffer byte address of source pixel (0,0).
REQ-002 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of memory reads in flight (1..8).
REQ-003 SHALL have parameter UNDER_COLOR, default 8'd9, meaning the palette index driven for pixels not yet fetched.
REQ-004 SHALL have the port list below; the clock and reset ports are fixed as stated:
  CLK  in  1  sole clock, rising edge
  RST  in  1  synchronous, active-high reset
  h_pos  in  10  horizontal counter from the VGA timing stage, 0..799
  v_pos  in  10  vertical counter from the VGA timing stage, 0..524
  mem_req  out  1  read request valid
  mem_addr  out  17  read byte address
  mem_gnt  in  1  request accepted this cycle when mem_req=1
  mem_rvalid  in  1  read data valid, returned in request order
  mem_rdata  in  8  read data (palette index)
  color  out  8  palette index to the VGA timing stage
  underrun  out  1  sticky flag: a displayed pixel was not yet fetched
  busy  out  1  high while a line fetch is in progress

Function
REQ-005 SHALL use a 320x240 source image, row-major, 1 byte per pixel, pixel address = FB_BASE + 320*y + x.
REQ-006 SHALL pixel-double the source image: active area h_pos 144..783, v_pos 33..512; x=(h_pos-144)>>1; y=(v_pos-33)>>1.
REQ-007 SHALL hold two 320x8 line banks; source line n SHALL be stored in bank n[0].
REQ-008 SHALL start the fetch of source line n when h_pos==0 and v_pos==31+2n, for n=0..239 (odd v_pos 31..509); no other positions SHALL start a fetch.
REQ-009 SHALL implement FSM IDLE->ISSUE on the fetch start, ISSUE->DRAIN after the 320th accepted request, DRAIN->IDLE when the outstanding count reaches 0 and all 320 bytes are written.
REQ-010 SHALL assert mem_req in ISSUE only while outstanding<MAX_OUTST, and SHALL hold mem_addr stable until mem_gnt.
REQ-011 SHALL increment the outstanding count on an accepted request and decrement it on mem_rvalid; a simultaneous accept and return SHALL leave it unchanged.
REQ-012 SHALL write each mem_rvalid byte to the next sequential x (0..319) of the bank being filled.
REQ-013 SHALL register color: the value at cycle t+1 corresponds to the h_pos/v_pos presented at cycle t.
REQ-014 SHALL drive color=0 outside the active area.
REQ-015 SHALL drive color=UNDER_COLOR in the active area when pixel x of line y has not yet been written for the current fetch, and SHALL set underrun in that cycle; underrun SHALL then remain set until reset.
REQ-016 SHALL ignore a fetch start that arrives while the FSM is not IDLE; it SHALL set underrun and let the current fetch finish.
REQ-017 SHALL track fill progress per bank as a 9-bit write pointer; a bank's pointer SHALL clear to 0 when its fetch starts.
REQ-018 SHALL assert busy in ISSUE and DRAIN only.

Reset
REQ-019 SHALL on RST=1 at a CLK edge set FSM=IDLE, outstanding=0, both write pointers=0, mem_req=0, mem_addr=0, color=0, underrun=0, busy=0.
REQ-020 SHALL abandon a fetch in progress when reset is applied mid-fetch; the memory SHALL share RST so that no pre-reset mem_rvalid arrives after reset.
REQ-021 SHALL leave line-bank contents undefined after reset; after reset they SHALL be read only through the pointer check in REQ-015.

Structure
REQ-022 SHALL place the VGA timing constants (144, 783, 33, 512, 800, 525), the 320x240 geometry and the address width in the shared package used by the timing stage.
REQ-023 SHALL implement the two line banks as one sub-module, vga_line_ram (dual bank, 1 write port, 1 registered read port).

Verification
REQ-024 Zero-latency memory (mem_gnt=1, rvalid one cycle after accept), FB byte at (x,y) = (x+y)%256 -> color at h_pos=146, v_pos=35 equals 2 one cycle later; underrun stays 0 for a full frame.
REQ-025 Memory with a 20-cycle return latency and MAX_OUTST=4 -> at most 4 outstanding at any time; each fetch completes before the next trigger; underrun stays 0.
REQ-026 mem_gnt held 0 from v_pos=31 until v_pos=33, h_pos=200 -> color=UNDER_COLOR at h_pos=144..201 of v_pos=33; underrun=1 and stays 1.
REQ-027 RST pulsed at v_pos=31, h_pos=100 (mid-fetch) -> next cycle mem_req=0, busy=0, color=0; the fetch restarts at the next trigger.
REQ-028 A mem_gnt accept and a mem_rvalid in the same cycle throughout a fetch -> outstanding stays 1; all 320 bytes land at x=0..319 in order.
REQ-029 Any position outside the active area, e.g. h_pos=100 or v_pos=520 -> color=0 one cycle later.
